// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: owns HI/LO, sequences multi-cycle MULT/DIV
// operations and raises the pipeline stall while an HI/LO user sits in E.
module mdu_ctrl #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        is_md_e,
  input  logic [1:0]  rd_sel,
  output logic [31:0] md_rdata,
  output logic        busy,
  output logic        stall_req
);

  localparam int MAX_CYC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   hi, lo, hi_nx, lo_nx;
  logic [31:0]   op_a, op_b, op_a_nx, op_b_nx;
  logic [2:0]    op_l, op_l_nx;

  // Result datapath works from the latched operands only.
  logic [63:0] mul_a, mul_b, prod;
  logic        div_signed, neg_a, neg_b;
  logic [31:0] abs_a, abs_b, uq, ur, quo, rem;

  always_comb begin
    mul_a = (op_l == OP_MULT) ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
    mul_b = (op_l == OP_MULT) ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
    prod  = mul_a * mul_b;
  end

  // Signed divide via magnitudes: 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    div_signed = (op_l == OP_DIV);
    neg_a      = div_signed & op_a[31];
    neg_b      = div_signed & op_b[31];
    abs_a      = neg_a ? (32'd0 - op_a) : op_a;
    abs_b      = neg_b ? (32'd0 - op_b) : op_b;
    uq         = (abs_b == 32'd0) ? 32'd0 : (abs_a / abs_b);
    ur         = (abs_b == 32'd0) ? 32'd0 : (abs_a % abs_b);
    quo        = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem        = neg_a ? (32'd0 - ur) : ur;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_l  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      op_a  <= op_a_nx;
      op_b  <= op_b_nx;
      op_l  <= op_l_nx;
    end
  end

  // Requests arriving while busy fall through the default: ignored entirely.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi;
    lo_nx    = lo;
    op_a_nx  = op_a;
    op_b_nx  = op_b;
    op_l_nx  = op_l;
    case (state)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              op_a_nx  = rs_val;
              op_b_nx  = rt_val;
              op_l_nx  = md_op;
              cnt_nx   = CW'(MUL_CYC);
              state_nx = MUL_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              op_a_nx  = rs_val;
              op_b_nx  = rt_val;
              op_l_nx  = md_op;
              cnt_nx   = CW'(DIV_CYC);
              state_nx = DIV_BUSY;
            end
            OP_MTHI: hi_nx = rs_val;
            OP_MTLO: lo_nx = rs_val;
            default: ;
          endcase
        end
      end
      MUL_BUSY: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_nx    = prod[63:32];
          lo_nx    = prod[31:0];
          state_nx = IDLE;
        end
      end
      DIV_BUSY: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (op_b != 32'd0) begin
            hi_nx = rem;
            lo_nx = quo;
          end
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign stall_req = is_md_e & (md_start | busy);
  assign md_rdata  = (rd_sel == 2'b01) ? hi :
                     (rd_sel == 2'b10) ? lo : 32'd0;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The module SHALL have the parameter MUL_CYC, default 5, meaning the number of busy cycles for MULT/MULTU.
REQ-002 The module SHALL have the parameter DIV_CYC, default 10, meaning the number of busy cycles for DIV/DIVU.
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The module SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have the port md_start, input, 1 bit: single-cycle request from the E stage to issue md_op.
REQ-006 The module SHALL have the port md_op, input, 3 bits: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; all other codes are no-op.
REQ-007 The module SHALL have the ports rs_val and rt_val, input, 32 bits each: forwarded operands.
REQ-008 The module SHALL have the port is_md_e, input, 1 bit: the E-stage instruction uses HI/LO (mult/div/mthi/mtlo/mfhi/mflo).
REQ-009 The module SHALL have the port rd_sel, input, 2 bits: 01 HI, 10 LO, all other values 0.
REQ-010 The module SHALL have the port md_rdata, output, 32 bits: the selected HI/LO value, combinational from the registers.
REQ-011 The module SHALL have the port busy, output, 1 bit: an operation is in progress.
REQ-012 The module SHALL have the port stall_req, output, 1 bit: request to freeze the F/D stages and bubble E.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL_BUSY and DIV_BUSY, with a down-counter cnt sized to hold DIV_CYC.
REQ-014 In IDLE, md_start with MULT/MULTU SHALL latch rs_val, rt_val and the op, load cnt=MUL_CYC and go to MUL_BUSY.
REQ-015 In IDLE, md_start with DIV/DIVU SHALL latch the operands, load cnt=DIV_CYC and go to DIV_BUSY.
REQ-016 In IDLE, md_start with MTHI/MTLO SHALL write rs_val to HI/LO at the next edge, without setting busy and without changing state.
REQ-017 busy SHALL be 1 exactly while the state is not IDLE, i.e. for MUL_CYC/DIV_CYC cycles starting the cycle after the md_start edge.
REQ-018 In a BUSY state cnt SHALL decrement each cycle; on the edge where cnt==1 the result SHALL be written to HI/LO, the state SHALL return to IDLE and busy SHALL fall.
REQ-019 MULT SHALL form the signed 64-bit product and MULTU the unsigned 64-bit product; HI gets bits[63:32] and LO gets bits[31:0].
REQ-020 DIV SHALL be signed, truncating toward zero, with LO=quotient and HI=remainder taking the sign of the dividend; DIVU SHALL be unsigned.
REQ-021 For DIV 0x80000000 / 0xFFFFFFFF, the result SHALL be LO=0x80000000, HI=0.
REQ-022 For divisor 0, HI/LO SHALL be left unchanged while the full DIV_CYC busy period still elapses.
REQ-023 md_start while busy SHALL be ignored (no latch, no HI/LO write); the upstream stall makes this illegal, and assertion checks flag it.
REQ-024 stall_req SHALL equal is_md_e & (md_start | busy), and SHALL be purely combinational.
REQ-025 md_rdata SHALL reflect the HI/LO register contents, so a value written at an edge is visible the cycle after that edge; HI/LO SHALL not bypass inputs.
REQ-026 The no-op md_op codes with md_start=1 SHALL cause no state change.

Reset
REQ-027 On reset_n=0, independent of clk: state=IDLE, cnt=0, HI=0, LO=0, latched operands=0; busy=0; stall_req follows REQ-024 with busy=0; md_rdata=0.
REQ-028 Reset asserted mid-operation SHALL abort it with no HI/LO write; after release the block SHALL accept a new md_start on the first edge.

Verification
REQ-029 MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-031 Preload HI=0x11, LO=0x22; DIV x/0 -> busy 10 cycles, then HI=0x11, LO=0x22; and 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-032 MTLO rs=0xABCD, rd_sel=10 -> md_rdata=0xABCD the next cycle, busy stays 0; is_md_e=1 with busy=1 -> stall_req=1, and with is_md_e=0 -> stall_req=0.
REQ-033 DIV started, reset_n pulsed low at busy cycle 4 -> busy=0 and HI=LO=0 immediately; a MULT 6x7 issued after release -> LO=42 after 5 cycles.
REQ-034 md_start MTHI issued during MUL_BUSY -> HI is unchanged by the MTHI and the product is committed normally.
